apb_uart_fifo: RTL and testbench

APB_UART_FIFO -- requirements
Module: apb_uart_fifo

---
 rtl/apb_uart_fifo_if.sv | 32 +++
 rtl/apb_uart_fifo.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_apb_uart_fifo.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_fifo_if.sv
// rtl/apb_uart_fifo_if.sv - APB register bus bundle for apb_uart_fifo
//
// Purpose: groups the APB request/response signals of the UART.
// Ports (signals):
//   PADDR_i[4:0]   byte address          (master -> slave)
//   PSEL_i         select                (master -> slave)
//   PENABLE_i      access phase          (master -> slave)
//   PWRITE_i       1 = write             (master -> slave)
//   PWDATA_i[31:0] write data            (master -> slave)
//   PRDATA_o[31:0] read data             (slave -> master)
//   PREADY_o       transfer complete     (slave -> master)
//   PSLVERR_o      transfer error        (slave -> master)
interface apb_uart_fifo_if;
    logic [4:0]  PADDR_i;
    logic        PSEL_i;
    logic        PENABLE_i;
    logic        PWRITE_i;
    logic [31:0] PWDATA_i;
    logic [31:0] PRDATA_o;
    logic        PREADY_o;
    logic        PSLVERR_o;

    modport master (
        output PADDR_i, PSEL_i, PENABLE_i, PWRITE_i, PWDATA_i,
        input  PRDATA_o, PREADY_o, PSLVERR_o
    );

    modport slave (
        input  PADDR_i, PSEL_i, PENABLE_i, PWRITE_i, PWDATA_i,
        output PRDATA_o, PREADY_o, PSLVERR_o
    );
endinterface

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB-controlled UART with TX/RX FIFOs
//
// Purpose: 16x-oversampled UART (5..8 data bits, optional even/odd parity,
// one stop bit) with a FIFO on each direction and an APB register interface.
// Ports (apb_uart_fifo):
//   PCLK_i      clock for all logic
//   PRESETn_i   asynchronous active-low reset
//   apb         APB slave bundle (apb_uart_fifo_if.slave)
//   rx_line_i   serial input, asynchronous to PCLK_i
//   tx_line_o   serial output, idles high
//   irq_o       registered level interrupt
// Ports (apb_uart_fifo_q): synchronous show-ahead FIFO, push/pop with
//   full/empty flags; data_o always presents the oldest entry.

module apb_uart_fifo_q #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, wp_d;
    logic [AW:0]      rp_q, rp_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign data_o  = mem_q[rp_q[AW-1:0]];

    // Both qualified against the flags as they stood before this cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (push_ok) wp_d = wp_q + (AW+1)'(1);
        if (pop_ok)  rp_d = rp_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wp_q[AW-1:0]] <= data_i;
    end
endmodule

module apb_uart_fifo #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd26
) (
    input  logic              PCLK_i,
    input  logic              PRESETn_i,
    apb_uart_fifo_if.slave    apb,
    input  logic              rx_line_i,
    output logic              tx_line_o,
    output logic              irq_o
);
    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_BAUD   = 3'd1;
    localparam logic [2:0] R_TXDATA = 3'd2;
    localparam logic [2:0] R_RXDATA = 3'd3;
    localparam logic [2:0] R_STATUS = 3'd4;
    localparam logic [2:0] R_ERR    = 3'd5;
    localparam logic [2:0] R_IEN    = 3'd6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH-1);

    // ---------------- APB decode ----------------
    logic       access, wr_acc, aligned;
    logic [2:0] reg_idx;

    assign access  = apb.PSEL_i & apb.PENABLE_i;
    assign wr_acc  = access & apb.PWRITE_i;
    assign aligned = (apb.PADDR_i[1:0] == 2'b00);
    assign reg_idx = apb.PADDR_i[4:2];
    assign apb.PREADY_o = access;

    logic [3:0]  ctrl_q;
    logic [15:0] baud_q;
    logic [2:0]  ien_q;
    logic [2:0]  err_q, err_d, err_set;
    logic        irq_q, irq_d;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_WIDTH-1:0] tx_rdata, rx_rdata, rx_shreg_q;
    logic                  tx_busy;
    logic [4:0]            status;
    logic [31:0]           prdata;
    logic                  slverr;

    assign status = {tx_busy, rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        prdata  = '0;
        slverr  = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        if (access) begin
            if (!aligned) begin
                slverr = 1'b1;
            end else begin
                case (reg_idx)
                    R_CTRL:   if (!apb.PWRITE_i) prdata = 32'(ctrl_q);
                    R_BAUD:   if (!apb.PWRITE_i) prdata = 32'(baud_q);
                    R_TXDATA: begin
                        if (!apb.PWRITE_i) slverr = 1'b1;
                        else if (tx_full)  slverr = 1'b1;   // character dropped
                        else               tx_push = 1'b1;
                    end
                    R_RXDATA: begin
                        if (apb.PWRITE_i)  slverr = 1'b1;
                        else if (rx_empty) slverr = 1'b1;   // reads as zero
                        else begin
                            prdata = 32'(rx_rdata);
                            rx_pop = 1'b1;
                        end
                    end
                    R_STATUS: begin
                        if (apb.PWRITE_i) slverr = 1'b1;
                        else              prdata = 32'(status);
                    end
                    R_ERR:    if (!apb.PWRITE_i) prdata = 32'(err_q);
                    R_IEN:    if (!apb.PWRITE_i) prdata = 32'(ien_q);
                    default:  slverr = 1'b1;
                endcase
            end
        end
    end

    assign apb.PRDATA_o  = prdata;
    assign apb.PSLVERR_o = slverr;

    logic ctrl_wr, baud_wr, ien_wr, err_wr;
    assign ctrl_wr = wr_acc & aligned & (reg_idx == R_CTRL);
    assign baud_wr = wr_acc & aligned & (reg_idx == R_BAUD);
    assign ien_wr  = wr_acc & aligned & (reg_idx == R_IEN);
    assign err_wr  = wr_acc & aligned & (reg_idx == R_ERR);

    // Hardware set is OR-ed after the clear so it wins on the same bit.
    assign err_d = (err_q & ~(err_wr ? apb.PWDATA_i[2:0] : 3'b000)) | err_set;
    assign irq_d = (ien_q[2] & (|err_q)) | (ien_q[1] & ~rx_empty) | (ien_q[0] & tx_empty);
    assign irq_o = irq_q;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            ctrl_q <= '0;
            baud_q <= BAUD_DIV_RST;
            ien_q  <= '0;
            err_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_q <= apb.PWDATA_i[3:0];
            if (baud_wr) baud_q <= apb.PWDATA_i[15:0];
            if (ien_wr)  ien_q  <= apb.PWDATA_i[2:0];
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    logic unused_pwdata;
    assign unused_pwdata = ^apb.PWDATA_i[31:16];

    // ---------------- FIFOs ----------------
    apb_uart_fifo_q #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (PCLK_i),
        .rst_ni  (PRESETn_i),
        .push_i  (tx_push),
        .data_i  (apb.PWDATA_i[DATA_WIDTH-1:0]),
        .pop_i   (tx_pop),
        .data_o  (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    apb_uart_fifo_q #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (PCLK_i),
        .rst_ni  (PRESETn_i),
        .push_i  (rx_push),
        .data_i  (rx_shreg_q),
        .pop_i   (rx_pop),
        .data_o  (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // ---------------- Baud / oversample tick ----------------
    logic [15:0] baud_cnt_q;
    logic        os_tick;

    assign os_tick = (baud_cnt_q == baud_q);

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i)             baud_cnt_q <= '0;
        else if (baud_wr || os_tick) baud_cnt_q <= '0;
        else                        baud_cnt_q <= baud_cnt_q + 16'd1;
    end

    // ---------------- Transmitter ----------------
    logic [2:0]            tx_state_q, tx_state_d;
    logic [3:0]            tx_tick_q, tx_tick_d;
    logic [2:0]            tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
    logic                  tx_par_en_q, tx_par_en_d;
    logic                  tx_pbit_q, tx_pbit_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_shreg_d  = tx_shreg_q;
        tx_par_en_d = tx_par_en_q;
        tx_pbit_d   = tx_pbit_q;
        tx_pop      = 1'b0;
        if (tx_state_q == S_IDLE) begin
            if (ctrl_q[0] && !tx_empty) begin
                tx_pop      = 1'b1;
                tx_shreg_d  = tx_rdata;
                // Parity mode frozen for the whole frame; ctrl[3] set means odd.
                tx_par_en_d = ^ctrl_q[3:2];
                tx_pbit_d   = (^tx_rdata) ^ ctrl_q[3];
                tx_tick_d   = '0;
                tx_bit_d    = '0;
                tx_state_d  = S_START;
            end
        end else if (os_tick) begin
            tx_tick_d = tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
                case (tx_state_q)
                    S_START:  tx_state_d = S_DATA;
                    S_DATA: begin
                        tx_shreg_d = tx_shreg_q >> 1;
                        if (tx_bit_q == LAST_BIT)
                            tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
                        else
                            tx_bit_d = tx_bit_q + 3'd1;
                    end
                    S_PARITY: tx_state_d = S_STOP;
                    default:  tx_state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            tx_state_q  <= S_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_shreg_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_pbit_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_shreg_q  <= tx_shreg_d;
            tx_par_en_q <= tx_par_en_d;
            tx_pbit_q   <= tx_pbit_d;
        end
    end

    assign tx_busy = (tx_state_q != S_IDLE);

    // Decoded from registers only, so the line follows reset immediately.
    always_comb begin
        case (tx_state_q)
            S_START:  tx_line_o = 1'b0;
            S_DATA:   tx_line_o = tx_shreg_q[0];
            S_PARITY: tx_line_o = tx_pbit_q;
            default:  tx_line_o = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_line_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_fall = rx_prev_q & ~sync2_q;

    logic [2:0]            rx_state_q, rx_state_d;
    logic [3:0]            rx_tick_q, rx_tick_d;
    logic [2:0]            rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shreg_d;
    logic                  rx_par_en_q, rx_par_en_d;
    logic                  rx_odd_q, rx_odd_d;
    logic                  rx_pbit_q, rx_pbit_d;
    logic                  rx_mid, rx_end;

    // Tick index 7 is the 8th oversample tick: centre of the bit.
    assign rx_mid = os_tick && (rx_tick_q == 4'd7);
    assign rx_end = os_tick && (rx_tick_q == 4'd15);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shreg_d  = rx_shreg_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_pbit_d   = rx_pbit_q;
        rx_push     = 1'b0;
        err_set     = 3'b000;
        if (rx_state_q == S_IDLE) begin
            if (ctrl_q[1] && rx_fall) begin
                rx_tick_d   = '0;
                rx_bit_d    = '0;
                rx_par_en_d = ^ctrl_q[3:2];
                rx_odd_d    = ctrl_q[3];
                rx_state_d  = S_START;
            end
        end else begin
            if (os_tick) rx_tick_d = rx_tick_q + 4'd1;
            case (rx_state_q)
                S_START: begin
                    if (rx_mid && sync2_q) rx_state_d = S_IDLE;   // glitch
                    else if (rx_end)       rx_state_d = S_DATA;
                end
                S_DATA: begin
                    if (rx_mid) rx_shreg_d = {sync2_q, rx_shreg_q[DATA_WIDTH-1:1]};
                    if (rx_end) begin
                        if (rx_bit_q == LAST_BIT)
                            rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
                        else
                            rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_mid) rx_pbit_d = sync2_q;
                    if (rx_end) rx_state_d = S_STOP;
                end
                default: begin
                    // Finish at mid-stop so a back-to-back start edge is not missed.
                    if (rx_mid) begin
                        rx_push    = 1'b1;
                        err_set[2] = ~sync2_q;
                        err_set[1] = rx_par_en_q & (rx_pbit_q ^ (^rx_shreg_q) ^ rx_odd_q);
                        err_set[0] = rx_full;
                        rx_state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            rx_state_q  <= S_IDLE;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shreg_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_pbit_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_shreg_q  <= rx_shreg_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_pbit_q   <= rx_pbit_d;
        end
    end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - directed self-checking bench for apb_uart_fifo
module tb_apb_uart_fifo;
    localparam int DEPTH = 16;
    localparam logic [4:0] A_CTRL = 5'h00, A_BAUD = 5'h04, A_TX = 5'h08, A_RX = 5'h0C;
    localparam logic [4:0] A_STAT = 5'h10, A_ERR = 5'h14, A_IEN = 5'h18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic tx_line, irq;
    wire  rx_line;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx_line : rx_drv;

    apb_uart_fifo_if bus ();

    apb_uart_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd26)) dut (
        .PCLK_i    (clk),
        .PRESETn_i (rst_n),
        .apb       (bus),
        .rx_line_i (rx_line),
        .tx_line_o (tx_line),
        .irq_o     (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;
    logic        err, rdy;
    logic        trace [0:199];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic e);
        @(posedge clk); #1;
        bus.PSEL_i = 1'b1; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b1;
        bus.PADDR_i = a; bus.PWDATA_i = d;
        @(posedge clk); #1;
        bus.PENABLE_i = 1'b1;
        @(negedge clk);
        e = bus.PSLVERR_o;
        @(posedge clk); #1;
        bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic e, output logic r);
        @(posedge clk); #1;
        bus.PSEL_i = 1'b1; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
        bus.PADDR_i = a;
        @(posedge clk); #1;
        bus.PENABLE_i = 1'b1;
        @(negedge clk);
        d = bus.PRDATA_o; e = bus.PSLVERR_o; r = bus.PREADY_o;
        @(posedge clk); #1;
        bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0;
    endtask

    task automatic do_reset();
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit, input logic stop_bit);
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
        drive_bit(1'b1);
    endtask

    task automatic wait_rx_nonempty(input string tag, input int max_reads);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_reads && !ok; i++) begin
            apb_rd(A_STAT, rd, err, rdy);
            if (!rd[2]) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b;
        int lows;
        logic found;

        bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
        bus.PADDR_i = '0; bus.PWDATA_i = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_tx_line", 32'(tx_line), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pready_idle", 32'(bus.PREADY_o), 32'd0);
        check("rst_prdata_idle", bus.PRDATA_o, 32'd0);
        apb_rd(A_STAT, rd, err, rdy);
        check("rst_status", rd, 32'h05);
        check("rst_pready_acc", 32'(rdy), 32'd1);
        apb_rd(A_CTRL, rd, err, rdy);
        check("rst_ctrl", rd, 32'h0);
        apb_rd(A_BAUD, rd, err, rdy);
        check("rst_baud", rd, 32'h1A);
        apb_rd(A_IEN, rd, err, rdy);
        check("rst_ien", rd, 32'h0);
        apb_rd(A_ERR, rd, err, rdy);
        check("rst_err", rd, 32'h0);

        // Address / access errors
        apb_rd(5'h01, rd, err, rdy);
        check("unaligned_err", 32'(err), 32'd1);
        apb_rd(5'h1C, rd, err, rdy);
        check("unmapped_err", 32'(err), 32'd1);
        apb_wr(A_STAT, 32'h1F, err);
        check("wr_status_err", 32'(err), 32'd1);
        apb_rd(A_TX, rd, err, rdy);
        check("rd_txdata_err", 32'(err), 32'd1);
        apb_rd(A_RX, rd, err, rdy);
        check("rx_empty_err", 32'(err), 32'd1);
        check("rx_empty_data", rd, 32'd0);
        apb_wr(A_IEN, 32'hFFFF_FFFF, err);
        check("ien_wr_ok", 32'(err), 32'd0);
        apb_rd(A_IEN, rd, err, rdy);
        check("ien_rd", rd, 32'h7);

        // TX FIFO overflow with tx disabled
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            apb_wr(A_TX, 32'(i), err);
            check($sformatf("tx_fill_err_%0d", i), 32'(err), (i == DEPTH) ? 32'd1 : 32'd0);
        end
        apb_rd(A_STAT, rd, err, rdy);
        check("tx_full_status", rd, 32'h06);
        check("tx_idle_line", 32'(tx_line), 32'd1);

        // Serial waveform of 0xA5, no parity
        do_reset();
        apb_wr(A_BAUD, 32'h0, err);
        apb_wr(A_CTRL, 32'h1, err);
        apb_wr(A_TX, 32'hA5, err);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!tx_line) found = 1'b1;
        end
        check("tx_start_seen", 32'(found), 32'd1);
        trace[0] = tx_line;
        for (int j = 1; j < 200; j++) begin
            @(negedge clk);
            trace[j] = tx_line;
        end
        lows = 0;
        for (int j = 0; j < 40; j++) begin
            if (trace[j]) break;
            lows++;
        end
        check("tx_start_len", 32'(lows), 32'd16);
        exp_b = 8'hA5;
        for (int k = 0; k < 8; k++)
            check($sformatf("tx_bit%0d", k), 32'(trace[16*(k+1)+8]), 32'(exp_b[k]));
        check("tx_stop", 32'(trace[152]), 32'd1);
        check("tx_after", 32'(trace[190]), 32'd1);
        apb_rd(A_STAT, rd, err, rdy);
        check("tx_done_status", rd, 32'h05);

        // Loopback with odd parity
        do_reset();
        loop_en = 1'b1;
        apb_wr(A_BAUD, 32'h0, err);
        apb_wr(A_CTRL, 32'hB, err);
        apb_wr(A_TX, 32'h3C, err);
        apb_rd(A_STAT, rd, err, rdy);
        check("lb_tx_busy", 32'(rd[4]), 32'd1);
        wait_rx_nonempty("lb_rx_wait", 200);
        apb_rd(A_RX, rd, err, rdy);
        check("lb_rxdata", rd, 32'h3C);
        check("lb_rx_err", 32'(err), 32'd0);
        apb_rd(A_ERR, rd, err, rdy);
        check("lb_err", rd, 32'h0);
        apb_rd(A_STAT, rd, err, rdy);
        check("lb_rx_empty", 32'(rd[2]), 32'd1);

        // Framing error and interrupt
        do_reset();
        apb_wr(A_BAUD, 32'h0, err);
        apb_wr(A_CTRL, 32'h2, err);
        apb_wr(A_IEN, 32'h4, err);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("fe_irq", 32'(irq), 32'd1);
        apb_rd(A_ERR, rd, err, rdy);
        check("fe_err", rd, 32'h4);
        apb_rd(A_RX, rd, err, rdy);
        check("fe_rxdata", rd, 32'h55);
        apb_wr(A_ERR, 32'h4, err);
        repeat (2) @(negedge clk);
        check("fe_irq_clr", 32'(irq), 32'd0);

        // Parity error (even mode, wrong parity bit), then a correct frame
        apb_wr(A_CTRL, 32'h6, err);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        apb_rd(A_ERR, rd, err, rdy);
        check("pe_err", rd, 32'h2);
        check("pe_irq", 32'(irq), 32'd1);
        apb_rd(A_RX, rd, err, rdy);
        check("pe_rxdata", rd, 32'h03);
        apb_wr(A_ERR, 32'h7, err);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        apb_rd(A_ERR, rd, err, rdy);
        check("pe_ok_err", rd, 32'h0);
        apb_rd(A_RX, rd, err, rdy);
        check("pe_ok_rxdata", rd, 32'h07);

        // RX overrun
        do_reset();
        apb_wr(A_BAUD, 32'h0, err);
        apb_wr(A_CTRL, 32'h2, err);
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
        apb_rd(A_ERR, rd, err, rdy);
        check("ovr_err", rd, 32'h1);
        apb_rd(A_STAT, rd, err, rdy);
        check("ovr_status", rd, 32'h09);
        for (int i = 0; i < DEPTH; i++) begin
            apb_rd(A_RX, rd, err, rdy);
            check($sformatf("ovr_rx_%0d", i), rd, 32'(8'h10 + i));
        end
        apb_rd(A_RX, rd, err, rdy);
        check("ovr_extra_data", rd, 32'd0);
        check("ovr_extra_err", 32'(err), 32'd1);

        // Reset in the middle of a frame
        do_reset();
        apb_wr(A_BAUD, 32'h0, err);
        apb_wr(A_CTRL, 32'h1, err);
        apb_wr(A_TX, 32'h00, err);
        repeat (20) @(negedge clk);
        check("mid_line_low", 32'(tx_line), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_line", 32'(tx_line), 32'd1);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_slverr", 32'(bus.PSLVERR_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apb_rd(A_STAT, rd, err, rdy);
        check("mid_rst_status", rd, 32'h05);
        apb_rd(A_CTRL, rd, err, rdy);
        check("mid_rst_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
